// File: rtl/ws2812_pkg.sv
//============================================================================
// ws2812_pkg : shared types and helpers for the multi-channel WS2812 serialiser
// Revision   : 1.0
//============================================================================
`default_nettype none

package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    BIT   = 3'd3,
    LATCH = 3'd4
  } ws_state_t;

  typedef struct packed {
    logic [7:0]  t1_h;
    logic [7:0]  t1_l;
    logic [7:0]  t0_h;
    logic [7:0]  t0_l;
    logic [15:0] rst;
  } ws_timing_t;

  localparam int BYTES_RGB  = 3;
  localparam int BYTES_RGBW = 4;

  // Bit period is the longer of the two symbol lengths, never zero.
  function automatic logic [8:0] ws_period(input ws_timing_t t);
    logic [8:0] s1;
    logic [8:0] s0;
    logic [8:0] p;
    s1 = {1'b0, t.t1_h} + {1'b0, t.t1_l};
    s0 = {1'b0, t.t0_h} + {1'b0, t.t0_l};
    p  = (s1 > s0) ? s1 : s0;
    if (p == 9'd0) p = 9'd1;
    return p;
  endfunction

  function automatic logic [15:0] ws_rst_len(input ws_timing_t t);
    return (t.rst == 16'd0) ? 16'd1 : t.rst;
  endfunction

  function automatic logic [7:0] ws_min1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_ch_buf.sv
//============================================================================
// ws2812_ch_buf : per-channel byte buffer, one write port, registered read
// Revision      : 1.0
//============================================================================
`default_nettype none

module ws2812_ch_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;
  logic       w_wr_ok;
  logic       w_rd_ok;

  // Addresses beyond the buffer are only reachable when DEPTH is not a power of two.
  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < c_depth);
  assign w_rd_ok = ({1'b0, i_rd_addr} < c_depth);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
    if (w_rd_ok) r_rd_data <= r_mem[i_rd_addr];
    else         r_rd_data <= 8'd0;
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/ws2812_multi_out.sv
//============================================================================
// ws2812_multi_out : CH_NUM WS2812 strips serialised in lockstep from one timer
// Revision         : 1.0
//============================================================================
`default_nettype none

module ws2812_multi_out
  import ws2812_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int LED_NUM = 64,
  parameter int AW      = $clog2(LED_NUM*4)
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [CH_NUM-1:0]              wr_en_in,
  input  logic [AW-1:0]                  wr_addr_in,
  input  logic [7:0]                     wr_data_in,
  input  logic                           frame_rdy_in,
  input  logic [$clog2(LED_NUM+1)-1:0]   led_cnt_in,
  input  logic                           rgbw_in,
  input  logic [CH_NUM-1:0]              ch_en_in,
  input  logic [7:0]                     t1_h_cnt_in,
  input  logic [7:0]                     t1_l_cnt_in,
  input  logic [7:0]                     t0_h_cnt_in,
  input  logic [7:0]                     t0_l_cnt_in,
  input  logic [15:0]                    rst_cnt_in,
  output logic [CH_NUM-1:0]              ws2812_data_out,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           drop_out
);

  localparam int c_lcw   = $clog2(LED_NUM+1);
  localparam int c_bw    = AW + 1;
  localparam int c_depth = LED_NUM * 4;
  localparam logic [c_bw-1:0] c_one_b = c_bw'(1);

  ws_state_t         r_state;
  ws_state_t         w_next;
  ws_timing_t        w_tim;

  logic [c_lcw-1:0]  w_led_sat;
  logic [c_bw-1:0]   w_led_ext;
  logic [c_bw-1:0]   w_byte_total;

  logic [8:0]        r_period;
  logic [8:0]        r_phase;
  logic [8:0]        w_phase_nxt;
  logic [8:0]        w_phase_cmp;
  logic [7:0]        r_h1;
  logic [7:0]        r_h0;
  logic [15:0]       r_rst_len;
  logic [15:0]       r_lat;
  logic [c_bw-1:0]   r_byte_total;
  logic [c_bw-1:0]   r_byte;
  logic [2:0]        r_bit;
  logic [CH_NUM-1:0] r_ch_en;
  logic [CH_NUM-1:0] r_out;
  logic [CH_NUM-1:0] w_out_nxt;
  logic              r_drop;
  logic [AW-1:0]     w_rd_addr;

  logic              w_bit_end;
  logic              w_byte_end;
  logic              w_last_bit;
  logic              w_lat_end;
  logic              w_load_sr;

  assign w_tim = '{t1_h: t1_h_cnt_in, t1_l: t1_l_cnt_in,
                   t0_h: t0_h_cnt_in, t0_l: t0_l_cnt_in, rst: rst_cnt_in};

  assign w_led_sat    = (led_cnt_in > c_lcw'(LED_NUM)) ? c_lcw'(LED_NUM) : led_cnt_in;
  assign w_led_ext    = c_bw'(w_led_sat);
  assign w_byte_total = rgbw_in ? (w_led_ext * c_bw'(BYTES_RGBW))
                                : (w_led_ext * c_bw'(BYTES_RGB));

  assign w_bit_end   = (r_phase == r_period - 9'd1);
  assign w_byte_end  = w_bit_end && (r_bit == 3'd7);
  assign w_last_bit  = w_byte_end && (r_byte == r_byte_total - c_one_b);
  assign w_lat_end   = (r_lat == r_rst_len - 16'd1);
  assign w_phase_nxt = w_bit_end ? 9'd0 : r_phase + 9'd1;
  assign w_phase_cmp = (r_state == LOAD) ? 9'd0 : w_phase_nxt;
  assign w_load_sr   = (r_state == LOAD) || ((r_state == BIT) && w_byte_end);

  // The next byte address is held for the whole current byte, so its data is
  // ready at the byte boundary even with a one-cycle bit period.
  assign w_rd_addr = (r_state == BIT) ? (r_byte[AW-1:0] + AW'(1)) : '0;

  generate
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic [7:0] w_rd_data;
      logic [7:0] r_shift;
      logic       w_msb_nxt;

      ws2812_ch_buf #(
        .DEPTH (c_depth),
        .AW    (AW)
      ) u_buf (
        .clk       (clk_in),
        .i_wr_en   (wr_en_in[c]),
        .i_wr_addr (wr_addr_in),
        .i_wr_data (wr_data_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
      );

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          r_shift <= 8'd0;
        end else if (w_load_sr) begin
          r_shift <= w_rd_data;
        end else if ((r_state == BIT) && w_bit_end) begin
          r_shift <= {r_shift[6:0], 1'b0};
        end
      end

      assign w_msb_nxt    = w_load_sr ? w_rd_data[7] : (w_bit_end ? r_shift[6] : r_shift[7]);
      assign w_out_nxt[c] = r_ch_en[c] &&
                            (w_phase_cmp < (w_msb_nxt ? {1'b0, r_h1} : {1'b0, r_h0}));
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (frame_rdy_in) w_next = (w_led_sat == '0) ? LATCH : FETCH;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = BIT;
      BIT:     if (w_last_bit) w_next = LATCH;
      LATCH:   if (w_lat_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_period     <= 9'd0;
      r_phase      <= 9'd0;
      r_h1         <= 8'd0;
      r_h0         <= 8'd0;
      r_rst_len    <= 16'd0;
      r_lat        <= 16'd0;
      r_byte_total <= '0;
      r_byte       <= '0;
      r_bit        <= 3'd0;
      r_ch_en      <= '0;
      r_out        <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_out  <= '0;
      r_drop <= frame_rdy_in && (r_state != IDLE);
      r_lat  <= (r_state == LATCH) ? r_lat + 16'd1 : 16'd0;
      case (r_state)
        IDLE: begin
          if (frame_rdy_in) begin
            r_period     <= ws_period(w_tim);
            r_h1         <= ws_min1(t1_h_cnt_in);
            r_h0         <= ws_min1(t0_h_cnt_in);
            r_rst_len    <= ws_rst_len(w_tim);
            r_byte_total <= w_byte_total;
            r_ch_en      <= ch_en_in;
          end
        end
        LOAD: begin
          r_phase <= 9'd0;
          r_bit   <= 3'd0;
          r_byte  <= '0;
          r_out   <= w_out_nxt;
        end
        BIT: begin
          r_phase <= w_phase_nxt;
          if (w_bit_end)  r_bit  <= r_bit + 3'd1;
          if (w_byte_end) r_byte <= r_byte + c_one_b;
          if (!w_last_bit) r_out <= w_out_nxt;
        end
        default: ;
      endcase
    end
  end

  assign ws2812_data_out = r_out;
  assign busy_out        = (r_state != IDLE);
  assign done_out        = (r_state == LATCH) && w_lat_end;
  assign drop_out        = r_drop;

endmodule

`default_nettype wire
